// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing with
// memory-wait timeout and illegal-instruction trap. Define BRANCH_EXT_EN for blt/bge/bltu/bgeu.
module multicycle_control_unit #(
  parameter int ALUCTRL_W   = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          i_instr,
  input  logic                 i_zero,
  input  logic                 i_lt,
  input  logic                 i_ltu,
  input  logic                 i_mem_ready,
  output logic                 o_mem_req,
  output logic                 o_mem_write,
  output logic                 o_adr_src,
  output logic                 o_ir_write,
  output logic                 o_pc_write,
  output logic                 o_reg_write,
  output logic [1:0]           o_alu_src_a,
  output logic [1:0]           o_alu_src_b,
  output logic [ALUCTRL_W-1:0] o_alu_ctrl,
  output logic [2:0]           o_imm_src,
  output logic [1:0]           o_result_src,
  output logic                 o_err
);

  typedef enum logic [3:0] {
    S_START, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_ERROR
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic [6:0]         w_opcode;
  logic [2:0]         w_funct3;
  logic [2:0]         w_alu_op;
  logic               w_br_ok;
  logic               w_br_taken;
  logic               w_wait_state;
  logic               w_timeout;
  logic               w_unused;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_unused = ^{i_instr[31], i_instr[29:15], i_instr[11:7], i_lt, i_ltu};

  // funct3 -> ALU op; sltu has no dedicated op and shares slt, sra shares srl.
  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  alu_decode = sub ? 3'b001 : 3'b000;
      3'b001:  alu_decode = 3'b110;
      3'b010,
      3'b011:  alu_decode = 3'b101;
      3'b100:  alu_decode = 3'b100;
      3'b101:  alu_decode = 3'b111;
      3'b110:  alu_decode = 3'b011;
      default: alu_decode = 3'b010;
    endcase
  endfunction

  always_comb begin
    w_br_ok    = 1'b1;
    w_br_taken = 1'b0;
    case (w_funct3)
      3'b000: w_br_taken = i_zero;
      3'b001: w_br_taken = !i_zero;
`ifdef BRANCH_EXT_EN
      3'b100: w_br_taken = i_lt;
      3'b101: w_br_taken = !i_lt;
      3'b110: w_br_taken = i_ltu;
      3'b111: w_br_taken = !i_ltu;
`endif
      default: w_br_ok = 1'b0;
    endcase
  end

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                        (r_state == S_MEMWRITE);
  // Fires on the cycle the counter would reach MEM_TIMEOUT; a same-cycle mem_ready wins.
  assign w_timeout = (MEM_TIMEOUT != 0) && w_wait_state && !i_mem_ready &&
                     (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_START;
      r_wait_cnt <= '0;
    end else begin
      if ((MEM_TIMEOUT != 0) && w_wait_state && !i_mem_ready)
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      else
        r_wait_cnt <= '0;

      case (r_state)
        S_START:  r_state <= S_FETCH;
        S_FETCH: begin
          if (i_mem_ready)    r_state <= S_DECODE;
          else if (w_timeout) r_state <= S_ERROR;
        end
        S_DECODE: begin
          case (w_opcode)
            OP_LOAD, OP_STORE: r_state <= S_MEMADR;
            OP_R:              r_state <= S_EXEC_R;
            OP_I:              r_state <= S_EXEC_I;
            OP_BRANCH:         r_state <= S_BRANCH;
            OP_JAL:            r_state <= S_JAL;
            default:           r_state <= S_ERROR;
          endcase
        end
        S_MEMADR: r_state <= (w_opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD: begin
          if (i_mem_ready)    r_state <= S_MEMWB;
          else if (w_timeout) r_state <= S_ERROR;
        end
        S_MEMWB:  r_state <= S_FETCH;
        S_MEMWRITE: begin
          if (i_mem_ready)    r_state <= S_FETCH;
          else if (w_timeout) r_state <= S_ERROR;
        end
        S_EXEC_R, S_EXEC_I, S_JAL: r_state <= S_ALUWB;
        S_ALUWB:  r_state <= S_FETCH;
        S_BRANCH: r_state <= w_br_ok ? S_FETCH : S_ERROR;
        S_ERROR:  r_state <= S_ERROR;
        default:  r_state <= S_START;
      endcase
    end
  end

  // Moore decode from the state register; async reset forces START, so every
  // write enable is low while rst is high.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    o_mem_req    = 1'b0;
    o_mem_write  = 1'b0;
    o_adr_src    = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_reg_write  = 1'b0;
    o_alu_src_a  = 2'b00;
    o_alu_src_b  = 2'b00;
    o_imm_src    = 3'b000;
    o_result_src = 2'b00;
    o_err        = 1'b0;
    w_alu_op     = 3'b000;
    case (r_state)
      S_FETCH: begin
        o_mem_req    = 1'b1;
        o_alu_src_b  = 2'b10;
        o_result_src = 2'b10;
        o_ir_write   = i_mem_ready;
        o_pc_write   = i_mem_ready;
      end
      S_DECODE: begin
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b01;
        if (w_opcode == OP_BRANCH)   o_imm_src = 3'b010;
        else if (w_opcode == OP_JAL) o_imm_src = 3'b011;
      end
      S_MEMADR: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b01;
        if (w_opcode == OP_STORE) o_imm_src = 3'b001;
      end
      S_MEMREAD: begin
        o_mem_req = 1'b1;
        o_adr_src = 1'b1;
      end
      S_MEMWB: begin
        o_reg_write  = 1'b1;
        o_result_src = 2'b01;
      end
      S_MEMWRITE: begin
        o_mem_req   = 1'b1;
        o_mem_write = 1'b1;
        o_adr_src   = 1'b1;
      end
      S_EXEC_R: begin
        o_alu_src_a = 2'b10;
        w_alu_op    = alu_decode(w_funct3, i_instr[30]);
      end
      S_EXEC_I: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b01;
        w_alu_op    = alu_decode(w_funct3, 1'b0);
      end
      S_ALUWB:  o_reg_write = 1'b1;
      S_BRANCH: begin
        o_alu_src_a = 2'b10;
        w_alu_op    = 3'b001;
        o_pc_write  = w_br_ok && w_br_taken;
      end
      S_JAL: begin
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b10;
        o_pc_write  = 1'b1;
      end
      S_ERROR:  o_err = 1'b1;
      default: ;
    endcase
  end

  assign o_alu_ctrl = ALUCTRL_W'(w_alu_op);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (ALUCTRL_W=4, MEM_TIMEOUT=4); expected
// control vectors are hand-written per state.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_instr;
  logic        i_zero, i_lt, i_ltu, i_mem_ready;
  logic        o_mem_req, o_mem_write, o_adr_src, o_ir_write, o_pc_write, o_reg_write;
  logic [1:0]  o_alu_src_a, o_alu_src_b, o_result_src;
  logic [3:0]  o_alu_ctrl;
  logic [2:0]  o_imm_src;
  logic        o_err;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_control_unit #(.ALUCTRL_W(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .i_instr(i_instr), .i_zero(i_zero), .i_lt(i_lt),
    .i_ltu(i_ltu), .i_mem_ready(i_mem_ready), .o_mem_req(o_mem_req),
    .o_mem_write(o_mem_write), .o_adr_src(o_adr_src), .o_ir_write(o_ir_write),
    .o_pc_write(o_pc_write), .o_reg_write(o_reg_write), .o_alu_src_a(o_alu_src_a),
    .o_alu_src_b(o_alu_src_b), .o_alu_ctrl(o_alu_ctrl), .o_imm_src(o_imm_src),
    .o_result_src(o_result_src), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // Field order: mem_req mem_write adr_src ir_write pc_write reg_write a b alu imm res err
  function automatic logic [19:0] pk(input logic mrq, mwr, adr, irw, pcw, rgw,
                                     input logic [1:0] a, b, input logic [3:0] alu,
                                     input logic [2:0] imm, input logic [1:0] res,
                                     input logic err);
    pk = {mrq, mwr, adr, irw, pcw, rgw, a, b, alu, imm, res, err};
  endfunction

  function automatic logic [19:0] obs();
    obs = pk(o_mem_req, o_mem_write, o_adr_src, o_ir_write, o_pc_write, o_reg_write,
             o_alu_src_a, o_alu_src_b, o_alu_ctrl, o_imm_src, o_result_src, o_err);
  endfunction

  localparam logic [19:0] V_ZERO  = 20'h0;
  localparam logic [19:0] V_FET1  = {6'b100110, 2'b00, 2'b10, 4'd0, 3'b000, 2'b10, 1'b0};
  localparam logic [19:0] V_FET0  = {6'b100000, 2'b00, 2'b10, 4'd0, 3'b000, 2'b10, 1'b0};
  localparam logic [19:0] V_DEC_I = {6'b000000, 2'b01, 2'b01, 4'd0, 3'b000, 2'b00, 1'b0};
  localparam logic [19:0] V_DEC_B = {6'b000000, 2'b01, 2'b01, 4'd0, 3'b010, 2'b00, 1'b0};
  localparam logic [19:0] V_DEC_J = {6'b000000, 2'b01, 2'b01, 4'd0, 3'b011, 2'b00, 1'b0};
  localparam logic [19:0] V_MA_L  = {6'b000000, 2'b10, 2'b01, 4'd0, 3'b000, 2'b00, 1'b0};
  localparam logic [19:0] V_MA_S  = {6'b000000, 2'b10, 2'b01, 4'd0, 3'b001, 2'b00, 1'b0};
  localparam logic [19:0] V_MRD   = {6'b101000, 2'b00, 2'b00, 4'd0, 3'b000, 2'b00, 1'b0};
  localparam logic [19:0] V_MWB   = {6'b000001, 2'b00, 2'b00, 4'd0, 3'b000, 2'b01, 1'b0};
  localparam logic [19:0] V_MWR   = {6'b111000, 2'b00, 2'b00, 4'd0, 3'b000, 2'b00, 1'b0};
  localparam logic [19:0] V_EXI   = {6'b000000, 2'b10, 2'b01, 4'd0, 3'b000, 2'b00, 1'b0};
  localparam logic [19:0] V_EXSUB = {6'b000000, 2'b10, 2'b00, 4'd1, 3'b000, 2'b00, 1'b0};
  localparam logic [19:0] V_EXAND = {6'b000000, 2'b10, 2'b00, 4'd2, 3'b000, 2'b00, 1'b0};
  localparam logic [19:0] V_AWB   = {6'b000001, 2'b00, 2'b00, 4'd0, 3'b000, 2'b00, 1'b0};
  localparam logic [19:0] V_BR_T  = {6'b000010, 2'b10, 2'b00, 4'd1, 3'b000, 2'b00, 1'b0};
  localparam logic [19:0] V_BR_N  = {6'b000000, 2'b10, 2'b00, 4'd1, 3'b000, 2'b00, 1'b0};
  localparam logic [19:0] V_JAL   = {6'b000010, 2'b01, 2'b10, 4'd0, 3'b000, 2'b00, 1'b0};
  localparam logic [19:0] V_ERR   = {6'b000000, 2'b00, 2'b00, 4'd0, 3'b000, 2'b00, 1'b1};

  task automatic check(input string tag, input logic [19:0] actual, input logic [19:0] expected);
    n_checks++;
    assert (actual === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %05h expected %05h", tag, actual, expected);
    end
  endtask

  // One clock cycle: drive inputs just after the falling edge, sample 1 ns later.
  task automatic cyc(input logic rdy, input logic z, input string tag, input logic [19:0] exp);
    @(negedge clk);
    i_mem_ready = rdy;
    i_zero      = z;
    #1;
    check(tag, obs(), exp);
  endtask

  // Leaves the DUT in its first post-reset (START) cycle.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    i_mem_ready = 1'b0;
    #1;
    check({tag, "_in_rst"}, obs(), V_ZERO);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check({tag, "_start"}, obs(), V_ZERO);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_instr = 32'h0; i_zero = 1'b0; i_lt = 1'b0; i_ltu = 1'b0; i_mem_ready = 1'b0;
    #12;

    // addi x1,x0,5: START FETCH DECODE EXEC_I ALUWB
    do_reset("addi");
    i_instr = 32'h00500093;
    cyc(1, 0, "addi_fetch", V_FET1);
    cyc(1, 0, "addi_decode", V_DEC_I);
    cyc(1, 0, "addi_exec", V_EXI);
    cyc(1, 0, "addi_wb", V_AWB);

    // lw with three MEMREAD wait cycles; the 4th cycle hits the timeout boundary with ready=1
    i_instr = 32'h0040A103;
    cyc(1, 0, "lw_fetch", V_FET1);
    cyc(1, 0, "lw_decode", V_DEC_I);
    cyc(1, 0, "lw_memadr", V_MA_L);
    cyc(0, 0, "lw_memrd_w1", V_MRD);
    cyc(0, 0, "lw_memrd_w2", V_MRD);
    cyc(0, 0, "lw_memrd_w3", V_MRD);
    cyc(1, 0, "lw_memrd_done", V_MRD);
    cyc(1, 0, "lw_memwb", V_MWB);

    i_instr = 32'h0020A223;
    cyc(1, 0, "sw_fetch", V_FET1);
    cyc(1, 0, "sw_decode", V_DEC_I);
    cyc(1, 0, "sw_memadr", V_MA_S);
    cyc(1, 0, "sw_memwr", V_MWR);

    i_instr = 32'h402081B3;
    cyc(1, 0, "sub_fetch", V_FET1);
    cyc(1, 0, "sub_decode", V_DEC_I);
    cyc(1, 0, "sub_exec", V_EXSUB);
    cyc(1, 0, "sub_wb", V_AWB);

    i_instr = 32'h0020F1B3;
    cyc(1, 0, "and_fetch", V_FET1);
    cyc(1, 0, "and_decode", V_DEC_I);
    cyc(1, 0, "and_exec", V_EXAND);
    cyc(1, 0, "and_wb", V_AWB);

    // addi with instr[30]=1 must still add
    i_instr = 32'h40000093;
    cyc(1, 0, "addi30_fetch", V_FET1);
    cyc(1, 0, "addi30_decode", V_DEC_I);
    cyc(1, 0, "addi30_exec", V_EXI);
    cyc(1, 0, "addi30_wb", V_AWB);

    i_instr = 32'h00208463;
    cyc(1, 1, "beq_t_fetch", V_FET1);
    cyc(1, 1, "beq_t_decode", V_DEC_B);
    cyc(1, 1, "beq_t_branch", V_BR_T);
    cyc(1, 0, "beq_n_fetch", V_FET1);
    cyc(1, 0, "beq_n_decode", V_DEC_B);
    cyc(1, 0, "beq_n_branch", V_BR_N);

    i_instr = 32'h00209463;
    cyc(1, 0, "bne_fetch", V_FET1);
    cyc(1, 0, "bne_decode", V_DEC_B);
    cyc(1, 0, "bne_branch", V_BR_T);

    i_instr = 32'h008000EF;
    cyc(1, 0, "jal_fetch", V_FET1);
    cyc(1, 0, "jal_decode", V_DEC_J);
    cyc(1, 0, "jal_jal", V_JAL);
    cyc(1, 0, "jal_wb", V_AWB);

    // Fetch timeout: four wait cycles then ERROR, held even when ready returns
    cyc(0, 0, "to_fetch_w1", V_FET0);
    cyc(0, 0, "to_fetch_w2", V_FET0);
    cyc(0, 0, "to_fetch_w3", V_FET0);
    cyc(0, 0, "to_fetch_w4", V_FET0);
    cyc(0, 0, "to_error", V_ERR);
    cyc(1, 0, "to_error_held", V_ERR);
    cyc(1, 0, "to_error_held2", V_ERR);

    do_reset("illegal");
    i_instr = 32'h0000007F;
    cyc(1, 0, "ill_fetch", V_FET1);
    cyc(1, 0, "ill_decode", V_DEC_I);
    cyc(1, 0, "ill_error", V_ERR);

    do_reset("blt");
    i_instr = 32'h0020C463;
    i_lt = 1'b1;
    cyc(1, 0, "blt_fetch", V_FET1);
    cyc(1, 0, "blt_decode", V_DEC_B);
`ifdef BRANCH_EXT_EN
    cyc(1, 0, "blt_branch", V_BR_T);
    cyc(1, 0, "blt_next", V_FET1);
`else
    cyc(1, 0, "blt_branch", V_BR_N);
    cyc(1, 0, "blt_error", V_ERR);
`endif
    i_lt = 1'b0;

    // Reset pulsed mid-cycle during a MEMWRITE wait
    do_reset("swrst");
    i_instr = 32'h0020A223;
    cyc(1, 0, "swrst_fetch", V_FET1);
    cyc(1, 0, "swrst_decode", V_DEC_I);
    cyc(1, 0, "swrst_memadr", V_MA_S);
    cyc(0, 0, "swrst_memwr_wait", V_MWR);
    #1;
    rst = 1'b1;
    #1;
    check("swrst_async_drop", obs(), V_ZERO);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("swrst_start", obs(), V_ZERO);
    cyc(1, 0, "swrst_fetch_again", V_FET1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Finite-state control unit for the multicycle RV32I datapath. It sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port. It generalises the single-cycle decoder with three additions: a configurable ALU control width, a `mem_req`/`mem_ready` handshake with a wait-state timeout, and illegal-instruction trapping. It sits between the instruction register, ALU flags and memory port on one side and the datapath mux selects and write enables on the other.

## Interface
- `ALUCTRL_W`, default 3: width of `alu_ctrl`; must be ≥3, and bits above [2:0] are driven 0.
- `MEM_TIMEOUT`, default 15: maximum consecutive cycles of `mem_ready` low in a memory wait state; 0 disables the timeout.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr` in 32: instruction register contents, valid from DECODE onward.
- `zero` in 1: ALU result == 0.
- `lt` in 1: signed rs1 < rs2.
- `ltu` in 1: unsigned rs1 < rs2.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access request.
- `mem_write` out 1: the access is a store.
- `adr_src` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load the instruction register.
- `pc_write` out 1: load the PC from the result bus.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 2: 00 = PC, 01 = oldPC, 10 = rs1.
- `alu_src_b` out 2: 00 = rs2, 01 = imm, 10 = constant 4.
- `alu_ctrl` out `ALUCTRL_W`: ALU operation select.
- `imm_src` out 3: immediate format; 000 = I, 001 = S, 010 = B, 011 = J.
- `result_src` out 2: 00 = ALUOut, 01 = memory data, 10 = ALU result.
- `err` out 1: sticky error flag (illegal instruction or memory timeout).

## Operation
- All outputs are Moore-decoded from the state register, except three conditional qualifiers:
  - `ir_write` and `pc_write` in FETCH, and `pc_write` in BRANCH, are qualified by `mem_ready`/condition as described below.
- `alu_ctrl` encoding: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
- States and transitions:
  - START: all outputs 0; next state FETCH.
  - FETCH: `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, add, `result_src`=10.
    - On `mem_ready`: `ir_write`=`pc_write`=1, next state DECODE.
    - Otherwise stay in FETCH.
  - DECODE: `alu_src_a`=01, `alu_src_b`=01, add; `imm_src` is B for opcode 1100011, J for 1101111, else I.
    - Opcode 0000011 or 0100011 → MEMADR.
    - 0110011 → EXEC_R; 0010011 → EXEC_I; 1100011 → BRANCH; 1101111 → JAL.
    - Any other opcode → ERROR.
  - MEMADR: rs1 + imm, add; `imm_src` is S for stores, I for loads.
    - Load → MEMREAD; store → MEMWRITE.
  - MEMREAD: `mem_req`=1, `adr_src`=1; on `mem_ready` → MEMWB.
  - MEMWB: `reg_write`=1, `result_src`=01; next state FETCH.
  - MEMWRITE: `mem_req`=`mem_write`=1, `adr_src`=1; on `mem_ready` → FETCH.
  - EXEC_R: `alu_src_a`=10, `alu_src_b`=00.
    - `alu_ctrl` decoded from funct3; funct3=000 with `instr[30]`=1 selects sub.
    - Next state ALUWB.
  - EXEC_I: as EXEC_R but `alu_src_b`=01; funct3=000 is always add. Next state ALUWB.
  - ALUWB: `reg_write`=1, `result_src`=00; next state FETCH.
  - BRANCH: `alu_src_a`=10, `alu_src_b`=00, sub, `result_src`=00.
    - `pc_write` = taken(funct3).
    - Unsupported funct3 → ERROR; otherwise → FETCH.
  - JAL: `alu_src_a`=01, `alu_src_b`=10, add, `result_src`=00, `pc_write`=1; next state ALUWB (writes oldPC+4).
  - ERROR: all outputs 0, `err`=1; held until `rst`.
- Memory timeout:
  - A wait counter clears on entry to FETCH, MEMREAD and MEMWRITE, and increments each cycle `mem_ready`=0 in those states.
  - When the counter reaches `MEM_TIMEOUT` with `mem_ready` still 0, the next state is ERROR.
  - If `mem_ready`=1 in the same cycle the counter reaches `MEM_TIMEOUT`, completion wins.

## Timing
- Reset: state START, counter 0, `err`=0, all outputs 0.
- `rst` asserted mid-instruction aborts immediately; no write enable may be asserted while `rst`=1.
- Zero-wait latencies:
  - lw 5 cycles; sw 4; R/I-type 4; branch 3; jal 4.
  - Each memory wait cycle adds 1.
- `mem_req` stays high continuously until the cycle in which `mem_ready` is sampled high.
- `err` rises in the first ERROR cycle.

## Configuration
- `BRANCH_EXT_EN` defined: BRANCH supports all six conditions.
  - 000 beq (`zero`), 001 bne (!`zero`), 100 blt (`lt`), 101 bge (!`lt`), 110 bltu (`ltu`), 111 bgeu (!`ltu`).
- Undefined: only beq and bne are supported; funct3 100–111 → ERROR with `err`=1.

## Test plan
- Reset, then `addi x1,x0,5` (0x00500093) with `mem_ready` tied 1 → states START, FETCH, DECODE, EXEC_I, ALUWB; `reg_write`=1 only in cycle 5 of the instruction; `alu_ctrl`=000.
- `lw` with `mem_ready` low for 3 cycles in MEMREAD → `mem_req` high for exactly 4 cycles; MEMWB follows; total 8 cycles.
- `beq` with `zero`=1, then with `zero`=0 → `pc_write` pulses in BRANCH only in the first case; each takes 3 cycles.
- `MEM_TIMEOUT`=4 with `mem_ready` stuck 0 in FETCH → ERROR entered after 4 wait cycles; `err`=1 and `mem_req`=0 thereafter, until `rst`.
- Opcode 0x7F, and (without `BRANCH_EXT_EN`) blt with funct3=100 → ERROR, `err`=1; with the macro, blt taken when `lt`=1.
- `rst` pulsed during MEMWRITE wait → `mem_write` drops asynchronously; after release, START then FETCH.
